// File: rtl/mac_dot_sched_if.sv
// Bundle between the dot-product sequencer and its job source, operand RAMs,
// MAC and result consumer. slave = sequencer side, master = environment side.
interface mac_dot_sched_if #(
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic              abort;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic              mac_clr;
  logic              mac_en;
  logic [ACC_W-1:0]  mac_acc;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic              result_ready;

  modport slave (
    input  start, len, a_base, b_base, abort, mac_acc, result_ready,
    output busy, rd_en, a_addr, b_addr, mac_clr, mac_en, result, result_valid
  );

  modport master (
    output start, len, a_base, b_base, abort, mac_acc, result_ready,
    input  busy, rd_en, a_addr, b_addr, mac_clr, mac_en, result, result_valid
  );
endinterface

// File: rtl/mac_dot_sched.sv
// Dot-product job sequencer: streams operand reads, strobes the MAC in step
// with read-data arrival and returns the captured accumulation.
module mac_dot_sched #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  mac_dot_sched_if.slave   bus,
  output logic [2:0]       state_dbg
);

  if (ACC_W < DATA_W) begin : g_bad_width
    $error("ACC_W must be at least DATA_W");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic              busy_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] a_addr_q;
  logic [ADDR_W-1:0] b_addr_q;
  logic              mac_clr_q;
  logic              mac_en_q;
  logic [ACC_W-1:0]  result_q;
  logic              result_valid_q;

  // Handshake: start is a request sampled only in IDLE (no queuing). result is
  // offered while result_valid is high and held stable until an edge with
  // result_ready high, which completes the transfer; abort cancels without one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      len_q          <= '0;
      cnt            <= '0;
      busy_q         <= 1'b0;
      rd_en_q        <= 1'b0;
      a_addr_q       <= '0;
      b_addr_q       <= '0;
      mac_clr_q      <= 1'b0;
      mac_en_q       <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else if (bus.abort && state != IDLE) begin
      state          <= IDLE;
      busy_q         <= 1'b0;
      rd_en_q        <= 1'b0;
      mac_clr_q      <= 1'b0;
      mac_en_q       <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= CLEAR;
            len_q     <= bus.len;
            cnt       <= '0;
            busy_q    <= 1'b1;
            mac_clr_q <= 1'b1;
            rd_en_q   <= (bus.len != '0);
            a_addr_q  <= bus.a_base;
            b_addr_q  <= bus.b_base;
          end
        end
        CLEAR: begin
          mac_clr_q <= 1'b0;
          if (len_q != '0) begin
            state    <= RUN;
            cnt      <= LEN_W'(1);
            mac_en_q <= 1'b1;
            rd_en_q  <= (len_q > LEN_W'(1));
            a_addr_q <= a_addr_q + ADDR_W'(1);
            b_addr_q <= b_addr_q + ADDR_W'(1);
          end else begin
            state   <= DRAIN;
            rd_en_q <= 1'b0;
          end
        end
        RUN: begin
          // cnt counts RUN cycles; read data lags addresses by one cycle, so the
          // last RUN cycle consumes data without issuing a new read.
          if (cnt == len_q) begin
            state    <= DRAIN;
            mac_en_q <= 1'b0;
            rd_en_q  <= 1'b0;
          end else begin
            cnt      <= cnt + LEN_W'(1);
            mac_en_q <= 1'b1;
            rd_en_q  <= ((cnt + LEN_W'(1)) < len_q);
            a_addr_q <= a_addr_q + ADDR_W'(1);
            b_addr_q <= b_addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          state          <= DONE;
          result_q       <= bus.mac_acc;
          result_valid_q <= 1'b1;
        end
        DONE: begin
          if (bus.result_ready) begin
            state          <= IDLE;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          busy_q         <= 1'b0;
          rd_en_q        <= 1'b0;
          mac_clr_q      <= 1'b0;
          mac_en_q       <= 1'b0;
          result_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.rd_en        = rd_en_q;
  assign bus.a_addr       = a_addr_q;
  assign bus.b_addr       = b_addr_q;
  assign bus.mac_clr      = mac_clr_q;
  assign bus.mac_en       = mac_en_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_mac_dot_sched.sv
// Bench for mac_dot_sched: operand RAMs and MAC modelled around the DUT,
// results compared against a dot product computed directly from the operands.
module tb_mac_dot_sched;

  logic       clk;
  logic       rst;
  logic [2:0] state_dbg;

  mac_dot_sched_if #(.ACC_W(16), .ADDR_W(8), .LEN_W(8)) bus ();

  mac_dot_sched #(.DATA_W(8), .ACC_W(16), .ADDR_W(8), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- environment: operand RAMs + MAC ----------------
  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];
  logic [7:0]  a_d, b_d;
  logic [15:0] acc;

  always @(posedge clk) begin
    if (bus.rd_en) begin
      a_d <= mem_a[bus.a_addr];
      b_d <= mem_b[bus.b_addr];
    end
    if (bus.mac_clr)     acc <= 16'd0;
    else if (bus.mac_en) acc <= acc + a_d * b_d;
  end
  assign bus.mac_acc = acc;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] last_res;
  int          da [256];
  int          db [256];
  int          checks;
  int          errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_dot(input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s += da[i] * db[i];
    return s[15:0];
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},    32'(bus.busy), 0);
    check({tag, "_rd_en"},   32'(bus.rd_en), 0);
    check({tag, "_a_addr"},  32'(bus.a_addr), 0);
    check({tag, "_b_addr"},  32'(bus.b_addr), 0);
    check({tag, "_mac_clr"}, 32'(bus.mac_clr), 0);
    check({tag, "_mac_en"},  32'(bus.mac_en), 0);
    check({tag, "_result"},  32'(bus.result), 0);
    check({tag, "_valid"},   32'(bus.result_valid), 0);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_job(input logic [7:0] ab, input logic [7:0] bb, input int n,
                         input int hold, input int abort_cyc, input bit abort_idle);
    int          cyc, rd_cnt, en_cnt, clr_cnt, valid_cyc;
    logic [7:0]  idx_a, idx_b;
    logic [15:0] exp;
    for (int i = 0; i < n; i++) begin
      idx_a = ab + 8'(i);
      idx_b = bb + 8'(i);
      mem_a[idx_a] = 8'(da[i]);
      mem_b[idx_b] = 8'(db[i]);
    end
    exp = ref_dot(n);
    if (abort_cyc == 0) exp_q.push_back(exp);

    bus.start  = 1'b1;
    bus.len    = 8'(n);
    bus.a_base = ab;
    bus.b_base = bb;
    bus.abort  = abort_idle;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.len    = 8'($urandom);
    bus.a_base = 8'($urandom);
    bus.b_base = 8'($urandom);

    cyc = 1; rd_cnt = 0; en_cnt = 0; clr_cnt = 0; valid_cyc = -1;
    while (cyc < n + 20) begin
      if (bus.rd_en) begin
        idx_a = ab + 8'(rd_cnt);
        idx_b = bb + 8'(rd_cnt);
        check("rd_cycle", cyc, rd_cnt + 1);
        check("a_addr", 32'(bus.a_addr), 32'(idx_a));
        check("b_addr", 32'(bus.b_addr), 32'(idx_b));
        rd_cnt++;
      end
      if (bus.mac_en) begin
        check("en_cycle", cyc, en_cnt + 2);
        en_cnt++;
      end
      if (bus.mac_clr) begin
        check("clr_cycle", cyc, 1);
        clr_cnt++;
      end
      if (bus.result_valid) begin
        valid_cyc = cyc;
        break;
      end
      if (cyc == abort_cyc) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy",   32'(bus.busy), 0);
        check("abort_valid",  32'(bus.result_valid), 0);
        check("abort_rd_en",  32'(bus.rd_en), 0);
        check("abort_mac_en", 32'(bus.mac_en), 0);
        check("abort_result", 32'(bus.result), 32'(last_res));
        return;
      end
      @(negedge clk);
      cyc++;
    end

    check("valid_cycle", valid_cyc, n + 3);
    check("rd_count", rd_cnt, n);
    check("en_count", en_cnt, n);
    check("clr_count", clr_cnt, 1);
    check("done_busy", 32'(bus.busy), 1);
    if (exp_q.size() == 0) check("exp_q_empty", 1, 0);
    else check("result", 32'(bus.result), 32'(exp_q.pop_front()));

    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(bus.result_valid), 1);
      check("hold_result", 32'(bus.result), 32'(exp));
      bus.start = (i == 1);
      @(negedge clk);
    end
    bus.start        = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    check("post_busy", 32'(bus.busy), 0);
    check("post_valid", 32'(bus.result_valid), 0);
    check("post_result", 32'(bus.result), 32'(exp));
    last_res = exp;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    checks = 0; errors = 0; last_res = 16'd0;
    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.a_base = '0; bus.b_base = '0;
    bus.abort = 1'b0; bus.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    for (int i = 0; i < 4; i++) begin da[i] = i + 1; db[i] = i + 5; end
    run_job(8'h10, 8'h10, 4, 0, 0, 1'b0);

    run_job(8'h33, 8'h44, 0, 0, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin da[i] = $urandom_range(0, 255); db[i] = $urandom_range(0, 255); end
    run_job(8'hFE, 8'h00, 4, 0, 0, 1'b0);

    da[0] = 255; da[1] = 255; db[0] = 255; db[1] = 255;
    run_job(8'h80, 8'h90, 2, 0, 0, 1'b0);

    for (int i = 0; i < 3; i++) begin da[i] = $urandom_range(0, 255); db[i] = $urandom_range(0, 255); end
    run_job(8'h20, 8'h60, 3, 5, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin da[i] = $urandom_range(1, 255); db[i] = $urandom_range(1, 255); end
    run_job(8'h40, 8'h50, 8, 0, 4, 1'b0);
    da[0] = 3; db[0] = 4;
    run_job(8'h00, 8'h01, 1, 0, 0, 1'b1);

    for (int j = 0; j < 15; j++) begin
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin da[i] = $urandom_range(0, 255); db[i] = $urandom_range(0, 255); end
      run_job(8'($urandom), 8'($urandom), n, $urandom_range(0, 2), 0, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin mem_a[8'(i)] = 8'd7; mem_b[8'(i + 8)] = 8'd9; end
    bus.start = 1'b1; bus.len = 8'd6; bus.a_base = 8'h00; bus.b_base = 8'h08;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    check("midrst_idle", 32'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_dot_sched.md
# mac_dot_sched

Sequencer for the 8x8 multiply-accumulate datapath. It accepts a dot-product job (two operand base addresses and a length) and issues sequential reads to two operand memories. It drives the MAC's clear/enable strobes in step with read-data arrival, captures the final 16-bit accumulation and returns it over a valid/ready handshake. It sits between the job-issuing control logic and one MAC instance plus its operand RAMs.

## Interface
- DATA_W, 8, operand width (MAC a/b inputs)
- ACC_W, 16, accumulator/result width
- ADDR_W, 8, operand memory address width
- LEN_W, 8, job length field width (0..2^LEN_W-1 pairs)
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; accepted only in IDLE
- len  in  LEN_W  number of operand pairs, sampled on accept
- a_base, b_base  in  ADDR_W  first addresses of operand vectors, sampled on accept
- abort  in  1  cancel the current job, return to IDLE
- busy  out  1  high in every state except IDLE
- rd_en  out  1  read strobe to both operand memories
- a_addr, b_addr  out  ADDR_W  read addresses
- mac_clr  out  1  clears MAC accumulator on next edge
- mac_en  out  1  MAC accumulates current memory data on next edge
- mac_acc  in  ACC_W  MAC accumulator value (registered in MAC)
- result  out  ACC_W  captured dot product
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result

## Operation
- Memory contract: data for the address presented with rd_en in cycle t is on the MAC inputs in cycle t+1. MAC contract: mac_clr sets acc to 0 at the edge, and mac_en adds a*b at the edge (ACC_W wrap). mac_acc reflects the update in the next cycle.
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: start=1 latches len, a_base, b_base, clears the pair counter, then goes to CLEAR. start is ignored in all other states (no queuing).
- CLEAR (1 cycle): mac_clr=1. If len>0: rd_en=1, addresses = base+0, then to RUN. If len=0: to DRAIN.
- RUN (len cycles): mac_en=1 every cycle. rd_en=1 with address base+k for k=1..len-1, then rd_en=0 in the final RUN cycle. Leave RUN after the len-th mac_en.
- DRAIN (1 cycle): result <= mac_acc at the edge, then to DONE.
- DONE: result_valid=1, result held stable. result_ready=1 goes to IDLE in the same edge. A new start is accepted only once back in IDLE.
- Addresses are computed modulo 2^ADDR_W, so the base+k sequence wraps past the top of memory.
- Arithmetic: no saturation. result equals the sum of a_i*b_i mod 2^ACC_W.
- abort=1 in any state other than IDLE goes to IDLE at the next edge. No result is produced, result_valid drops, and result keeps its old value. abort has priority over result_ready. abort in IDLE is ignored, and start in the same cycle is still accepted.
- rd_en, addresses, mac_clr, mac_en, busy and result_valid decode from registered state and counter only, with no combinational path from inputs.

## Timing
- Reset values: state IDLE, busy=0, rd_en=0, a_addr=b_addr=0, mac_clr=0, mac_en=0, result=0, result_valid=0.
- Accept at cycle 0. CLEAR is cycle 1. RUN is cycles 2..len+1. DRAIN is cycle len+2. result_valid is first high in cycle len+3.
- Latency from accept to result_valid: len+3 cycles (3 for len=0).
- Throughput: one operand pair per cycle in RUN. Minimum job-to-job spacing is len+4 cycles with result_ready held high.
- rst mid-job overrides everything, including abort, and forces reset values at the next edge.

## Test plan
- a=[1,2,3,4], b=[5,6,7,8], a_base=b_base=0x10, len=4 -> addresses 0x10..0x13 on cycles 1..4, mac_en on cycles 2..5, result=70 (0x0046) with valid in cycle 7.
- len=0 -> one mac_clr, no rd_en, no mac_en, result=0 with valid in cycle 3.
- a_base=0xFE, b_base=0x00, len=4 -> a_addr sequence 0xFE, 0xFF, 0x00, 0x01 and b_addr sequence 0x00..0x03.
- All operands 255, len=2 -> result=64514 (130050 mod 65536).
- result_ready held 0 for 5 cycles in DONE -> result_valid and result stable throughout. A start pulse during DONE is ignored, and a start after return to IDLE is accepted.
- abort in RUN cycle 3 of a len=8 job -> IDLE next cycle, busy=0, result_valid never asserted, previous result unchanged. An immediate new len=1 job (3x4) -> result=12.
